// File: rtl/reg_load_fifo_if.sv
// reg_load_fifo_if: producer write handshake, hold stall and register load outputs of reg_load_fifo.
interface reg_load_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             hold;
    logic             en_out;
    logic [WIDTH-1:0] d_out;
    logic [AW:0]      count;
    modport master (output wr_valid, wr_data, hold, input wr_ready, en_out, d_out, count);
    modport slave (input wr_valid, wr_data, hold, output wr_ready, en_out, d_out, count);
endinterface

// File: rtl/reg_load_fifo.sv
// reg_load_fifo: FIFO buffering producer writes and draining one word per cycle onto register en/d.
// Optional sticky overflow flag output ovf when REG_LOAD_FIFO_OVF_EN is defined.
module reg_load_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
`ifdef REG_LOAD_FIFO_OVF_EN
    output logic ovf,
`endif
    reg_load_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             en_q;
    logic [WIDTH-1:0] d_q;
    logic             push, pop;
    // wr_ready ignores a same-cycle pop so the full path stays short
    assign bus.wr_ready = cnt != (AW+1)'(DEPTH);
    assign push = bus.wr_valid & bus.wr_ready;
    assign pop = (cnt != '0) & ~bus.hold;
    assign bus.count = cnt;
    assign bus.en_out = en_q;
    assign bus.d_out = d_q;
    always_ff @(posedge clk)
        if (push && !rst) mem[wr_ptr] <= bus.wr_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            en_q <= 1'b0;
            d_q <= '0;
        end else begin
            en_q <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                d_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end
`ifdef REG_LOAD_FIFO_OVF_EN
    always_ff @(posedge clk)
        if (rst) ovf <= 1'b0;
        else if (bus.wr_valid && !bus.wr_ready) ovf <= 1'b1;
`endif
endmodule
